// File: rtl/hpu_pkg.sv
// Shared types for the HPU LSU data-memory arbiter: requester source, arbiter
// state and tag-FIFO entry layout.
package hpu_pkg;

  typedef enum logic {
    SRC_LD   = 1'b0,
    SRC_ATOM = 1'b1
  } dmem_src_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ATOM_RD   = 2'd1,
    ATOM_WAIT = 2'd2,
    ATOM_WR   = 2'd3
  } dmem_arb_state_e;

  typedef struct packed {
    dmem_src_e src;
    logic      discard;
  } dmem_tag_t;

endpackage

// File: rtl/hpu_lsu_dmem_tag_fifo.sv
// In-order tag FIFO for outstanding data-memory reads. Flush marks every held
// entry as discard so its response is popped but not delivered.
module hpu_lsu_dmem_tag_fifo
  import hpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  dmem_src_e push_src,
  input  logic      pop,
  input  logic      flush,
  output dmem_tag_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dmem_tag_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  // A push into a full FIFO is only legal alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (flush)
        for (int i = 0; i < DEPTH; i++) mem_q[i].discard <= 1'b1;
      if (do_push) begin
        mem_q[wr_q].src     <= push_src;
        mem_q[wr_q].discard <= flush;
        wr_q                <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hpu_lsu_dmem_arb.sv
// Shared data-memory port arbiter for LSU loads, store drain and atomic RMW.
// Optional perf counters: define HPU_LSU_DMEM_ARB_PERF_EN.
module hpu_lsu_dmem_arb
  import hpu_pkg::*;
#(
  parameter int ADDR_WTH      = 32,
  parameter int DATA_WTH      = 32,
  parameter int MAX_OUTST     = 4,
  parameter int ST_STARVE_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_en_i,
  input  logic                  ld_req_i,
  input  logic [ADDR_WTH-1:0]   ld_addr_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WTH-1:0]   ld_rdata_o,
  input  logic                  st_req_i,
  input  logic [ADDR_WTH-1:0]   st_addr_i,
  input  logic [DATA_WTH-1:0]   st_wdata_i,
  input  logic [DATA_WTH/8-1:0] st_wstrb_i,
  output logic                  st_gnt_o,
  input  logic                  atom_req_i,
  input  logic [ADDR_WTH-1:0]   atom_addr_i,
  output logic                  atom_gnt_o,
  output logic                  atom_rvalid_o,
  output logic [DATA_WTH-1:0]   atom_rdata_o,
  input  logic                  atom_wvalid_i,
  input  logic [DATA_WTH-1:0]   atom_wdata_i,
  output logic                  atom_wdone_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WTH-1:0]   mem_addr_o,
  output logic [DATA_WTH-1:0]   mem_wdata_o,
  output logic [DATA_WTH/8-1:0] mem_wstrb_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WTH-1:0]   mem_rdata_i,
  output logic                  busy_o
`ifdef HPU_LSU_DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_st_starve_cnt_o,
  output logic [31:0]           perf_rd_full_stall_cnt_o
`endif
);

  localparam int SC_W = $clog2(ST_STARVE_MAX + 1);

  dmem_arb_state_e     state_q, state_d;
  logic [SC_W-1:0]     starve_q;
  logic [ADDR_WTH-1:0] atom_addr_q;
  logic                sel_ld, sel_st, sel_at_rd, sel_at_wr;
  logic                st_starved, rd_ok;
  logic                fifo_full, fifo_empty, fifo_pop, hd_disc, rsp_ld, rsp_at;
  dmem_tag_t           fifo_head;

  assign st_starved = (starve_q == SC_W'(ST_STARVE_MAX));
  // A response popping this cycle frees the slot a new read would take.
  assign rd_ok      = !fifo_full || mem_rvalid_i;

  assign fifo_pop = mem_rvalid_i && !fifo_empty && !rst_i;
  assign hd_disc  = fifo_head.discard || flush_en_i;
  assign rsp_ld   = fifo_pop && (fifo_head.src == SRC_LD);
  assign rsp_at   = fifo_pop && (fifo_head.src == SRC_ATOM);

  always_comb begin
    state_d     = state_q;
    sel_ld      = 1'b0;
    sel_st      = 1'b0;
    sel_at_rd   = 1'b0;
    sel_at_wr   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (st_req_i && st_starved)           sel_st  = 1'b1;
          else if (atom_req_i && !flush_en_i)   state_d = ATOM_RD;
          else if (ld_req_i && !flush_en_i && rd_ok) sel_ld = 1'b1;
          else if (st_req_i)                    sel_st  = 1'b1;
        end
        ATOM_RD: begin
          if (flush_en_i) state_d = IDLE;
          else if (rd_ok) begin
            sel_at_rd = 1'b1;
            if (mem_ready_i) state_d = ATOM_WAIT;
          end
        end
        ATOM_WAIT: begin
          if (rsp_at) state_d = hd_disc ? IDLE : ATOM_WR;
        end
        ATOM_WR: begin
          if (flush_en_i) state_d = IDLE;
          else if (atom_wvalid_i) begin
            sel_at_wr = 1'b1;
            if (mem_ready_i) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (sel_ld) mem_addr_o = ld_addr_i;
    if (sel_at_rd) mem_addr_o = atom_addr_i;
    if (sel_st) begin
      mem_we_o    = 1'b1;
      mem_addr_o  = st_addr_i;
      mem_wdata_o = st_wdata_i;
      mem_wstrb_o = st_wstrb_i;
    end
    if (sel_at_wr) begin
      mem_we_o    = 1'b1;
      mem_addr_o  = atom_addr_q;
      mem_wdata_o = atom_wdata_i;
      mem_wstrb_o = '1;
    end
  end

  assign mem_req_o    = sel_ld || sel_st || sel_at_rd || sel_at_wr;
  assign ld_gnt_o     = sel_ld && mem_ready_i;
  assign st_gnt_o     = sel_st && mem_ready_i;
  assign atom_gnt_o   = sel_at_rd && mem_ready_i;
  assign atom_wdone_o = sel_at_wr && mem_ready_i;

  assign ld_rvalid_o   = rsp_ld && !hd_disc;
  assign atom_rvalid_o = rsp_at && !hd_disc;
  assign ld_rdata_o    = ld_rvalid_o ? mem_rdata_i : '0;
  assign atom_rdata_o  = atom_rvalid_o ? mem_rdata_i : '0;
  assign busy_o        = !rst_i && ((state_q != IDLE) || !fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      atom_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (st_gnt_o)                        starve_q <= '0;
      else if (st_req_i && !st_starved)    starve_q <= starve_q + SC_W'(1);
      if (atom_gnt_o) atom_addr_q <= atom_addr_i;
    end
  end

  hpu_lsu_dmem_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (ld_gnt_o || atom_gnt_o),
    .push_src (atom_gnt_o ? SRC_ATOM : SRC_LD),
    .pop      (fifo_pop),
    .flush    (flush_en_i),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef HPU_LSU_DMEM_ARB_PERF_EN
  logic rd_want;
  assign rd_want = !rst_i && !flush_en_i &&
                   (((state_q == IDLE) && ld_req_i && !atom_req_i && !(st_req_i && st_starved)) ||
                    (state_q == ATOM_RD));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_st_starve_cnt_o     <= '0;
      perf_rd_full_stall_cnt_o <= '0;
    end else begin
      if (st_req_i && st_starved && (perf_st_starve_cnt_o != '1))
        perf_st_starve_cnt_o <= perf_st_starve_cnt_o + 32'd1;
      if (rd_want && !rd_ok && (perf_rd_full_stall_cnt_o != '1))
        perf_rd_full_stall_cnt_o <= perf_rd_full_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
